sramlike_axi_bridge: RTL and testbench
======================================

SRAMLIKE_AXI_BRIDGE -- requirements
Module: sramlike_axi_bridge

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  synchronous reset, active-low.
REQ-003 data_req  input  1  CPU data request valid.
REQ-004 data_wr  input  1  1 = write, 0 = read.
REQ-005 data_size  input  3  bytes = 2^size (0/1/2 legal).
REQ-006 data_wstrb  input  4  write byte enables.
REQ-007 data_addr  input  32  byte address.
REQ-008 data_wdata  input  32  write data.
REQ-009 data_addr_ok  output  1  request accepted this cycle.
REQ-010 data_data_ok  output  1  one-cycle completion pulse.
REQ-011 data_rdata  output  32  read data, valid with data_data_ok.
REQ-012 araddr/arsize  output  32/3  AXI read address and size.
REQ-013 arvalid  output  1 / arready  input  1  AR handshake.
REQ-014 rdata  input  32 / rvalid  input  1 / rready  output  1  R channel.
REQ-015 awaddr/awsize  output  32/3  AXI write address and size.
REQ-016 awvalid  output  1 / awready  input  1  AW handshake.
REQ-017 wdata/wstrb  output  32/4 / wvalid  output  1 / wready  input  1  W channel.
REQ-018 bvalid  input  1 / bready  output  1  B channel.
REQ-019 IDs, len (single beat), burst, lock, cache, prot, wlast=1 are constants tied off outside; rresp/bresp are ignored.

Function
REQ-020 FSM states: IDLE, AR, R, AWW, B; one transaction outstanding at most.
REQ-021 data_addr_ok = data_req & (state==IDLE), combinational.
REQ-022 On accept: latch addr, size, wstrb, wdata; wr -> AWW, else -> AR.
REQ-023 AR: arvalid=1, araddr/arsize from latch, held stable until arready; on arvalid&arready -> R.
REQ-024 R: rready=1; on rvalid: data_rdata <= rdata, data_data_ok pulses next cycle, -> IDLE.
REQ-025 AWW: awvalid and wvalid both asserted on entry; each drops independently after its own handshake; both complete (same or different cycles) -> B.
REQ-026 B: bready=1; on bvalid: data_data_ok pulses next cycle, -> IDLE.
REQ-027 data_data_ok is registered, exactly one cycle per accepted request, in request order.
REQ-028 data_rdata holds its value until the next R handshake; unchanged by writes.
REQ-029 A new request is accepted in the cycle data_data_ok pulses (state is IDLE); no idle bubble required.
REQ-030 Minimum read latency: accept cycle 0, arvalid cycle 1, rvalid cycle 2, data_data_ok cycle 3 (ready inputs always high).
REQ-031 Minimum write latency: accept 0, aw/w handshake 1, bvalid 2, data_data_ok 3.
REQ-032 No valid signal deasserts before its handshake; address/data/strobe stable while valid.
REQ-033 rvalid/bvalid outside R/B states are ignored.

Reset
REQ-034 resetn=0: state IDLE, arvalid/awvalid/wvalid/rready/bready=0, data_data_ok=0, data_rdata=0, latches=0.
REQ-035 Reset mid-transaction drops it: no data_data_ok, and no request is accepted until resetn returns high.

Verification
REQ-036 Read, all readies high, addr 0x1FC0_0004 size 2, rdata 0xDEADBEEF -> araddr 0x1FC0_0004 cycle 1, data_data_ok + data_rdata 0xDEADBEEF cycle 3.
REQ-037 Write addr 0x8000_0010, wstrb 0x3, wdata 0x1234_5678; awready 1 cycle before wready -> awvalid drops first, wvalid held, single data_data_ok after bvalid.
REQ-038 arready low 5 cycles -> arvalid and araddr stable throughout; data_req meanwhile gets no data_addr_ok.
REQ-039 Back-to-back read then write, zero-wait slave -> second accepted in first's data_data_ok cycle; 2 pulses total, in order.
REQ-040 resetn low while in R with rvalid pending -> next cycle all valids/readies 0, no data_data_ok; fresh read after release completes normally.

Source files
------------

// File: rtl/sramlike_axi_bridge.sv
// sramlike_axi_bridge
// Bridges a CPU SRAM-like data port onto a single-beat AXI master. At most one
// transaction is in flight: a request is accepted only while idle, then the AR/R
// or AW+W/B channels are run, and a one-cycle data_ok pulse closes it out.
//
// Ports
//   clk, resetn                     clock, synchronous active-low reset
//   data_req/wr/size/wstrb/addr/wdata  CPU request (accepted via data_addr_ok)
//   data_addr_ok                    combinational accept strobe
//   data_data_ok, data_rdata        registered completion pulse and read data
//   ar*/r*                          AXI read address / read data channels
//   aw*/w*/b*                       AXI write address / write data / response
// IDs, len, burst, lock, cache, prot and wlast are tied off outside this block.
module sramlike_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AWW  = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_data_ok;
  logic [31:0] r_rdata;

  logic w_accept;
  logic w_aw_done;
  logic w_w_done;

  // Gated by resetn so nothing is accepted while reset is held.
  assign w_accept  = data_req & resetn & (r_state == S_IDLE);
  // A channel counts as done once its valid has dropped or it handshakes now.
  assign w_aw_done = ~r_awvalid | awready;
  assign w_w_done  = ~r_wvalid  | wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_wstrb   <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_addr  <= data_addr;
          r_size  <= data_size;
          r_wstrb <= data_wstrb;
          r_wdata <= data_wdata;
          if (data_wr) begin
            r_state   <= S_AWW;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end else begin
            r_state <= S_AR;
          end
        end
        S_AR: if (arready) r_state <= S_R;
        S_R: if (rvalid) begin
          r_rdata   <= rdata;
          r_data_ok <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_AWW: begin
          // AW and W retire independently; leave once both have handshaken.
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) r_state <= S_B;
        end
        S_B: if (bvalid) begin
          r_data_ok <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_addr_ok = w_accept;
  assign data_data_ok = r_data_ok;
  assign data_rdata   = r_rdata;

  assign araddr  = r_addr;
  assign arsize  = r_size;
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);

  assign awaddr  = r_addr;
  assign awsize  = r_size;
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wvalid  = r_wvalid;
  assign bready  = (r_state == S_B);

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
module tb_sramlike_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        data_req, data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  sramlike_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour: 0 random, 1 zero-wait, 2 AW before W, 3 AR stalled 5 cycles,
  // 4 zero-wait but R never returns.
  int mode = 1;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          fast;
    int          acc;
  } txn_t;

  txn_t pend[$];
  int   done_cyc[$];

  // Slave memory contents as seen by reads.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h1FC0_0004) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0F0F) + 32'h0001_0203;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- AXI slave model ----------------
  bit          f_ar, f_r, f_aw, f_w, f_b;
  bit          r_pend, aw_done, w_done;
  logic [31:0] r_dat;
  int          r_dly, b_dly, ar_wait;

  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = '0;
    r_pend = 0; aw_done = 0; w_done = 0; r_dat = '0; r_dly = 0; b_dly = 0; ar_wait = 0;
    f_ar = 0; f_r = 0; f_aw = 0; f_w = 0; f_b = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      end else begin
        if (f_r) begin rvalid = 0; r_pend = 0; end
        if (f_b) begin bvalid = 0; aw_done = 0; w_done = 0; end
        if (!rvalid) rdata = $urandom;
        if (r_pend && !rvalid && mode != 4) begin
          if (r_dly == 0) begin rvalid = 1; rdata = r_dat; end else r_dly--;
        end
        if (aw_done && w_done && !bvalid) begin
          if (b_dly == 0) bvalid = 1; else b_dly--;
        end
        case (mode)
          0: begin
            arready = ($urandom_range(0, 2) != 0);
            awready = ($urandom_range(0, 2) != 0);
            wready  = ($urandom_range(0, 2) != 0);
          end
          2: begin arready = 1; awready = 1; wready = aw_done; end
          3: begin arready = (ar_wait >= 5); awready = 1; wready = 1; end
          default: begin arready = 1; awready = 1; wready = 1; end
        endcase
      end
      #4;
      f_ar = resetn && arvalid && arready;
      f_r  = resetn && rvalid  && rready;
      f_aw = resetn && awvalid && awready;
      f_w  = resetn && wvalid  && wready;
      f_b  = resetn && bvalid  && bready;
      if (!resetn) begin
        r_pend = 0; aw_done = 0; w_done = 0; ar_wait = 0;
      end
      if (f_ar) begin
        r_pend = 1; r_dat = mem_rd(araddr); ar_wait = 0;
        r_dly = (mode == 0) ? $urandom_range(0, 3) : 0;
      end else if (arvalid) ar_wait++;
      if (f_aw) begin aw_done = 1; b_dly = (mode == 0) ? $urandom_range(0, 3) : 0; end
      if (f_w) w_done = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit          rst_prev;
    logic [31:0] exp_rdata;
    int          c_ar, c_r, c_aw, c_w, c_b;
    bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize, p_awsize;
    logic [3:0]  p_wstrb;
    txn_t        h;
    rst_prev = 1; exp_rdata = '0;
    c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_arsize = '0; p_awsize = '0; p_wstrb = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_prev) begin
        chk("reset_ctl", 32'({arvalid, awvalid, wvalid, rready, bready, data_data_ok}), 32'd0);
        chk("reset_rdata", data_rdata, 32'd0);
        exp_rdata = '0;
      end else begin
        if (p_arv && !p_arr) begin
          chk("ar_hold", 32'(arvalid), 32'd1);
          chk("ar_stable", {araddr[31:3], arsize}, {p_araddr[31:3], p_arsize});
          chk("ar_addr_lo", 32'(araddr[2:0]), 32'(p_araddr[2:0]));
        end
        if (p_awv && !p_awr) begin
          chk("aw_hold", 32'(awvalid), 32'd1);
          chk("aw_stable", awaddr ^ 32'(awsize), p_awaddr ^ 32'(p_awsize));
        end
        if (p_wv && !p_wr) begin
          chk("w_hold", 32'(wvalid), 32'd1);
          chk("w_stable", wdata ^ 32'(wstrb), p_wdata ^ 32'(p_wstrb));
        end
        if (arvalid && c_ar != 0) chk("ar_reassert", 32'(arvalid), 32'd0);
        if (awvalid && c_aw != 0) chk("aw_reassert", 32'(awvalid), 32'd0);
        if (wvalid && c_w != 0)   chk("w_reassert", 32'(wvalid), 32'd0);

        if (arvalid && arready) begin
          if (pend.size() == 0) chk("ar_no_txn", 32'd1, 32'd0);
          else begin
            chk("ar_is_read", 32'(pend[0].wr), 32'd0);
            chk("araddr", araddr, pend[0].addr);
            chk("arsize", 32'(arsize), 32'(pend[0].size));
            if (pend[0].fast) chk("ar_lat", 32'(cyc - pend[0].acc), 32'd1);
          end
          c_ar++;
        end
        if (rvalid && rready) begin
          chk("r_after_ar", 32'(c_ar), 32'd1);
          c_r++;
        end
        if (awvalid && awready) begin
          if (pend.size() == 0) chk("aw_no_txn", 32'd1, 32'd0);
          else begin
            chk("aw_is_write", 32'(pend[0].wr), 32'd1);
            chk("awaddr", awaddr, pend[0].addr);
            chk("awsize", 32'(awsize), 32'(pend[0].size));
            if (pend[0].fast) chk("aw_lat", 32'(cyc - pend[0].acc), 32'd1);
          end
          c_aw++;
        end
        if (wvalid && wready) begin
          if (pend.size() == 0) chk("w_no_txn", 32'd1, 32'd0);
          else begin
            chk("wdata", wdata, pend[0].wdata);
            chk("wstrb", 32'(wstrb), 32'(pend[0].wstrb));
            if (pend[0].fast) chk("w_lat", 32'(cyc - pend[0].acc), 32'd1);
          end
          c_w++;
        end
        if (bvalid && bready) c_b++;

        if (data_data_ok) begin
          if (pend.size() == 0) chk("spurious_data_ok", 32'd1, 32'd0);
          else begin
            h = pend.pop_front();
            if (h.wr) begin
              chk("wr_hs_counts", 32'({8'(c_aw), 8'(c_w), 8'(c_b), 8'(c_ar + c_r)}), 32'h01010100);
            end else begin
              chk("rd_hs_counts", 32'({8'(c_ar), 8'(c_r), 8'(c_aw + c_w + c_b)}), 32'h010100);
              exp_rdata = mem_rd(h.addr);
            end
            if (h.fast) chk("done_lat", 32'(cyc - h.acc), 32'd3);
            done_cyc.push_back(cyc);
          end
          c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
        end
        chk("data_rdata", data_rdata, exp_rdata);
        chk("addr_ok", 32'(data_addr_ok), 32'(data_req && resetn && pend.size() == 0));
      end
      p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arsize = arsize;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awsize = awsize;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      rst_prev = resetn;
      if (!resetn) begin
        pend.delete();
        c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_b = 0;
      end
    end
  end

  // ---------------- CPU-side stimulus ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [3:0] st, input logic [31:0] wd, output int acc);
    txn_t t;
    bit   ok;
    ok = 0; acc = -1;
    data_req = 1; data_wr = wr; data_addr = a; data_size = sz;
    data_wstrb = st; data_wdata = wd;
    for (int k = 0; k < 300 && !ok; k++) begin
      #3;
      if (data_addr_ok) begin
        t.wr = wr; t.addr = a; t.size = sz; t.wstrb = st; t.wdata = wd;
        t.fast = (mode == 1); t.acc = cyc;
        pend.push_back(t);
        acc = cyc; ok = 1;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    data_req = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && pend.size() != 0; k++) @(negedge clk);
    chk("idle_timeout", 32'(pend.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int a1, a2, n0;
    data_req = 0; data_wr = 0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    resetn = 0;
    repeat (3) @(negedge clk);
    #1 resetn = 1;
    @(negedge clk);

    // zero-wait read of the boot vector
    mode = 1;
    do_req(0, 32'h1FC0_0004, 3'd2, 4'hF, 32'h0, a1);
    wait_idle();
    chk("boot_read", data_rdata, 32'hDEADBEEF);

    // write with AW accepted a cycle before W; read data must be untouched
    mode = 2;
    do_req(1, 32'h8000_0010, 3'd1, 4'h3, 32'h1234_5678, a1);
    wait_idle();
    chk("rdata_after_write", data_rdata, 32'hDEADBEEF);

    // AR stalled for 5 cycles while another request waits
    mode = 3;
    do_req(0, 32'h0000_1230, 3'd2, 4'hF, 32'h0, a1);
    do_req(0, 32'h0000_4560, 3'd1, 4'hF, 32'h0, a2);
    chk("ar_stall_accept_gap", 32'(a2 - a1), 32'd8);
    wait_idle();

    // back-to-back read then write, zero-wait
    mode = 1;
    n0 = done_cyc.size();
    do_req(0, 32'h0000_2000, 3'd2, 4'hF, 32'h0, a1);
    do_req(1, 32'h0000_2004, 3'd2, 4'hC, 32'hCAFE_F00D, a2);
    wait_idle();
    chk("b2b_pulses", 32'(done_cyc.size() - n0), 32'd2);
    if (done_cyc.size() - n0 == 2) begin
      chk("b2b_accept_in_ok_cycle", 32'(a2), 32'(done_cyc[n0]));
      chk("b2b_second_lat", 32'(done_cyc[n0 + 1] - a2), 32'd3);
    end

    // reset while the read sits in R
    mode = 4;
    do_req(0, 32'h0000_3000, 3'd2, 4'hF, 32'h0, a1);
    repeat (2) @(negedge clk);
    chk("r_pending_before_reset", 32'(rready), 32'd1);
    #1 resetn = 0;
    repeat (2) @(negedge clk);
    #1 resetn = 1;
    @(negedge clk);
    mode = 1;
    n0 = done_cyc.size();
    do_req(0, 32'h1FC0_0004, 3'd2, 4'hF, 32'h0, a1);
    wait_idle();
    chk("post_reset_read", data_rdata, 32'hDEADBEEF);
    chk("post_reset_pulses", 32'(done_cyc.size() - n0), 32'd1);

    // randomized traffic against a randomly stalling slave
    mode = 0;
    repeat (150) begin
      do_req(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 2)),
             4'($urandom), $urandom, a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
